// File: rtl/magnetron_pkg.sv
// Shared types and default sizing for the magnetron power controller.
package magnetron_pkg;

  localparam int unsigned MAG_PWM_PERIOD_DEF = 10;
  localparam int unsigned MAG_LEVEL_W_DEF    = 4;

  typedef enum logic [1:0] {
    MAG_IDLE  = 2'd0,
    MAG_RUN   = 2'd1,
    MAG_PAUSE = 2'd2
  } mag_state_e;

endpackage

// File: rtl/duty_slot_counter.sv
// Slot counter for duty-cycled power: wraps every PWM_PERIOD cycles while enabled
// and reports whether the current slot falls inside the on-portion of the window.
module duty_slot_counter
  import magnetron_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = MAG_PWM_PERIOD_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              clr,
  input  logic [$clog2(PWM_PERIOD+1)-1:0]   level,
  output logic                              slot_on
);

  localparam int unsigned SLOT_W = $clog2(PWM_PERIOD);
  localparam int unsigned LVL_W  = $clog2(PWM_PERIOD + 1);
  localparam int unsigned CMP_W  = (SLOT_W > LVL_W) ? SLOT_W : LVL_W;

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // clr wins over en so the first cycle of a (re)start always sits in slot 0
  always_comb begin
    slot_d = '0;
    if (en && !clr) begin
      if (slot_q == SLOT_W'(PWM_PERIOD - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_on = CMP_W'(slot_q) < CMP_W'(level);

endmodule

// File: rtl/magnetron_power_ctrl.sv
// Magnetron control FSM: start/pause/clear handling, power-level latch and
// door interlock around a duty-cycling slot counter.
module magnetron_power_ctrl
  import magnetron_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = MAG_PWM_PERIOD_DEF,
  parameter int unsigned LEVEL_W    = MAG_LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               running,
  output logic               paused,
  output logic               done
);

  localparam int unsigned LVL_W = $clog2(PWM_PERIOD + 1);

  mag_state_e        state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              startn_q, startn_d;
  logic              done_q, done_d;
  logic              press;
  logic              slot_on;
  logic [LVL_W-1:0]  level_clamped;

  assign press = startn_q & ~startn;
  assign level_clamped = (power_level >= LEVEL_W'(PWM_PERIOD)) ? LVL_W'(PWM_PERIOD)
                                                               : LVL_W'(power_level);

  // Per-cycle priority: clear > door open > stop > timer expiry > start press
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    done_d   = 1'b0;
    startn_d = startn;
    case (state_q)
      MAG_IDLE: begin
        if (clearn && door_closed && stopn && press) begin
          state_d = MAG_RUN;
          level_d = level_clamped;
        end
      end
      MAG_RUN: begin
        if (!clearn) begin
          state_d = MAG_IDLE;
        end else if (!door_closed || !stopn) begin
          state_d = MAG_PAUSE;
        end else if (timer_done) begin
          state_d = MAG_IDLE;
          done_d  = 1'b1;
        end
      end
      MAG_PAUSE: begin
        if (!clearn) begin
          state_d = MAG_IDLE;
        end else if (door_closed && stopn && press) begin
          state_d = MAG_RUN;
        end
      end
      default: state_d = MAG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MAG_IDLE;
      level_q  <= '0;
      startn_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      startn_q <= startn_d;
      done_q   <= done_d;
    end
  end

  duty_slot_counter #(
    .PWM_PERIOD(PWM_PERIOD)
  ) u_slot (
    .clk    (clk),
    .reset  (reset),
    .en     (state_d == MAG_RUN),
    .clr    (state_q != MAG_RUN),
    .level  (level_q),
    .slot_on(slot_on)
  );

  // door_closed bypasses the registers so an opening door cuts power immediately
  assign mag_on  = (state_q == MAG_RUN) & slot_on & door_closed;
  assign running = (state_q == MAG_RUN);
  assign paused  = (state_q == MAG_PAUSE);
  assign done    = done_q;

endmodule
